pool_engine_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one max-pooling engine among `NUM_REQ` requesters (CNN layer stages or channel-group workers). It grants the engine to one requester at a time and drives the engine's `enable` pulse. It tracks the engine's level-type completion flag by rising-edge detection and returns a one-cycle `done` (or `err` on timeout) to the granted requester. It sits between the layer controllers and the single pooling datapath, and `sel` steers the feature-map input mux and output write-back.

---
 rtl/pool_engine_arbiter.sv | 152 +++++++++++++++
 tb/tb_pool_engine_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pool_engine_arbiter.sv
// Round-robin arbiter/sequencer sharing one max-pooling engine among NUM_REQ requesters.
// Grants, pulses the engine enable, and returns done/err on the engine's done-flag rising edge or on timeout.
module pool_engine_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024,
    parameter int SEL_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               pool_enable,
    input  logic               pool_done,
    output logic [NUM_REQ-1:0] done,
    output logic               err
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQ - 1);
    localparam logic [TW-1:0]    T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]    T_MAX    = '1;

    logic [2:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               busy_q, busy_d;
    logic               pool_enable_q, pool_enable_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               err_q, err_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               pd_q, pd_d;

    logic               rise;
    logic               pick_vld;
    logic [SEL_W-1:0]   pick_idx;
    logic [SEL_W:0]     cand;

    assign rise = pool_done & ~pd_q;

    // First set request at or above ptr, wrapping; cand is one bit wider so ptr+i cannot overflow.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (SEL_W+1)'(i);
            if (cand >= (SEL_W+1)'(NUM_REQ))
                cand = cand - (SEL_W+1)'(NUM_REQ);
            if (!pick_vld && req[cand[SEL_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        sel_d         = sel_q;
        ptr_d         = ptr_q;
        timer_d       = timer_q;
        pool_enable_d = 1'b0;
        done_d        = '0;
        err_d         = 1'b0;
        pd_d          = pool_done;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    sel_d             = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    ptr_d             = (pick_idx == LAST_IDX) ? '0 : pick_idx + SEL_W'(1);
                    state_d           = S_GRANT;
                end
            end
            S_GRANT: begin
                pool_enable_d = 1'b1;
                state_d       = S_START;
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rise) begin
                    done_d[sel_q] = 1'b1;
                    grant_d       = '0;
                    state_d       = S_DONE;
                end else if (timer_q == T_LAST) begin
                    done_d[sel_q] = 1'b1;
                    err_d         = 1'b1;
                    grant_d       = '0;
                    state_d       = S_DONE;
                end else if (timer_q != T_MAX) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            sel_q         <= '0;
            ptr_q         <= '0;
            busy_q        <= 1'b0;
            pool_enable_q <= 1'b0;
            done_q        <= '0;
            err_q         <= 1'b0;
            timer_q       <= '0;
            pd_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            sel_q         <= sel_d;
            ptr_q         <= ptr_d;
            busy_q        <= busy_d;
            pool_enable_q <= pool_enable_d;
            done_q        <= done_d;
            err_q         <= err_d;
            timer_q       <= timer_d;
            pd_q          <= pd_d;
        end
    end

    assign grant       = grant_q;
    assign sel         = sel_q;
    assign busy        = busy_q;
    assign pool_enable = pool_enable_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_pool_engine_arbiter.sv
// Directed bench for pool_engine_arbiter: table of single operations plus hand-written
// sequences for late completion after timeout and reset in the middle of WAIT.
module tb_pool_engine_arbiter;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   sel;
    logic               busy;
    logic               pool_enable;
    logic               pool_done;
    logic [NUM_REQ-1:0] done;
    logic               err;

    int checks = 0;
    int errors = 0;

    pool_engine_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant), .sel(sel), .busy(busy),
        .pool_enable(pool_enable), .pool_done(pool_done), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Engine model: clears its flag clr_dly edges after seeing enable, sets it set_dly edges after (0 = never).
    logic [15:0] eng_t, eng_n, clr_dly, set_dly;
    logic        eng_pd;
    assign eng_n     = pool_enable ? 16'd1 : ((eng_t != 16'd0) ? eng_t + 16'd1 : 16'd0);
    assign pool_done = eng_pd;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_t  <= 16'd0;
            eng_pd <= 1'b0;
        end else begin
            eng_t <= eng_n;
            if (eng_n != 16'd0 && eng_n == clr_dly) eng_pd <= 1'b0;
            if (eng_n != 16'd0 && eng_n == set_dly) eng_pd <= 1'b1;
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [15:0] clr;
        logic [15:0] setd;
        int          sel;
        int          lat;
        logic        err;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " grant"}, 32'(grant), 32'd0);
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " pool_enable"}, 32'(pool_enable), 32'd0);
        chk({nm, " done"}, 32'(done), 32'd0);
        chk({nm, " err"}, 32'(err), 32'd0);
    endtask

    // Edge 0 is the edge just before the call; req is driven 1 time unit after it.
    task automatic run_op(input vec_t v, input int id);
        string nm;
        nm      = $sformatf("op%0d", id);
        req     = v.req;
        clr_dly = v.clr;
        set_dly = v.setd;
        for (int k = 1; k <= v.lat; k++) begin
            @(posedge clk);
            #1;
            chk({nm, " pool_enable"}, 32'(pool_enable), 32'(k == 2));
            if (k < v.lat) begin
                chk({nm, " grant"}, 32'(grant), 32'd1 << v.sel);
                chk({nm, " busy"}, 32'(busy), 32'd1);
                chk({nm, " done early"}, 32'(done), 32'd0);
                chk({nm, " err early"}, 32'(err), 32'd0);
                if (k == 1) chk({nm, " sel"}, 32'(sel), 32'(v.sel));
            end else begin
                chk({nm, " done"}, 32'(done), 32'd1 << v.sel);
                chk({nm, " err"}, 32'(err), 32'(v.err));
                chk({nm, " grant at done"}, 32'(grant), 32'd0);
                chk({nm, " busy at done"}, 32'(busy), 32'd1);
            end
        end
        req = '0;
        @(posedge clk);
        #1;
        chk_idle({nm, " after"});
        chk({nm, " sel hold"}, 32'(sel), 32'(v.sel));
    endtask

    initial begin
        // req, clr, set, sel, lat, err
        tbl[0]  = '{4'b0001, 16'd1, 16'd3,  0, 6,  1'b0};  // single request
        tbl[1]  = '{4'b1111, 16'd1, 16'd3,  1, 6,  1'b0};  // round robin
        tbl[2]  = '{4'b1111, 16'd1, 16'd3,  2, 6,  1'b0};
        tbl[3]  = '{4'b1111, 16'd1, 16'd3,  3, 6,  1'b0};
        tbl[4]  = '{4'b1111, 16'd1, 16'd3,  0, 6,  1'b0};
        tbl[5]  = '{4'b0100, 16'd1, 16'd3,  2, 6,  1'b0};  // leaves ptr=3
        tbl[6]  = '{4'b0101, 16'd1, 16'd3,  0, 6,  1'b0};  // wrap and skip
        tbl[7]  = '{4'b0101, 16'd1, 16'd3,  2, 6,  1'b0};
        tbl[8]  = '{4'b1000, 16'd2, 16'd5,  3, 8,  1'b0};  // stale flag cleared late
        tbl[9]  = '{4'b0110, 16'd1, 16'd3,  1, 6,  1'b0};
        tbl[10] = '{4'b0001, 16'd1, 16'd10, 0, 11, 1'b1};  // timeout, late completion

        reset   = 1'b1;
        req     = '0;
        clr_dly = 16'd1;
        set_dly = 16'd0;
        #1;
        chk_idle("reset async");
        chk("reset sel", 32'(sel), 32'd0);
        @(posedge clk);
        #1;
        chk_idle("reset held");
        reset = 1'b0;

        for (int i = 0; i < 11; i++) run_op(tbl[i], i);

        // Late engine completion lands in IDLE; must not pulse anything.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk_idle($sformatf("late rise %0d", k));
        end

        // Reset two cycles after the enable pulse, while in WAIT.
        req     = 4'b0001;
        clr_dly = 16'd1;
        set_dly = 16'd0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) chk("rst seq pool_enable", 32'(pool_enable), 32'd1);
        end
        chk("rst seq grant", 32'(grant), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk_idle("rst mid-wait");
        chk("rst mid-wait sel", 32'(sel), 32'd0);
        req = '0;
        @(posedge clk);
        #1;
        chk_idle("rst mid-wait held");
        reset = 1'b0;
        // ptr must restart at 0: with req=0011, requester 0 wins.
        run_op('{4'b0011, 16'd1, 16'd3, 0, 6, 1'b0}, 20);
        run_op('{4'b0010, 16'd1, 16'd3, 1, 6, 1'b0}, 21);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
